// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversampled SCL/SDA, START/STOP detection, fixed-address match,
// per-byte ACK, and a single-entry AXI-Stream output buffer.
`timescale 1ns/1ps
module i2c_slave_rx #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  stop_det,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_DATA     = 3'd3,
    S_DATA_ACK = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  logic [2:0]            r_scl;
  logic [2:0]            r_sda;
  state_t                r_state;
  logic [2:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_ack;
  logic                  r_sda_oe;
  logic                  r_busy;
  logic                  r_stop_det;
  logic                  r_tvalid;
  logic [DATA_WIDTH-1:0] r_tdata;

  state_t                w_state_nxt;
  logic [2:0]            w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_ack_nxt;
  logic                  w_sda_oe_nxt;
  logic                  w_busy_nxt;
  logic                  w_stop_det_nxt;
  logic                  w_tvalid_nxt;
  logic [DATA_WIDTH-1:0] w_tdata_nxt;

  // Index 1 is the synchronized level, index 2 the history sample used for edge detection.
  logic                  w_scl_rise;
  logic                  w_scl_fall;
  logic                  w_start;
  logic                  w_stop;
  logic [DATA_WIDTH-1:0] w_byte;
  logic                  w_match;

  assign w_scl_rise = r_scl[1] & ~r_scl[2];
  assign w_scl_fall = ~r_scl[1] & r_scl[2];
  assign w_start    = ~r_sda[1] & r_sda[2] & r_scl[1];
  assign w_stop     = r_sda[1] & ~r_sda[2] & r_scl[1];
  assign w_byte     = {r_shift[DATA_WIDTH-2:0], r_sda[1]};
  assign w_match    = (w_byte[DATA_WIDTH-1:1] == SLAVE_ADDR) && (w_byte[0] == 1'b0);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_scl      <= 3'b111;
      r_sda      <= 3'b111;
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_shift    <= '0;
      r_ack      <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_stop_det <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
    end else begin
      r_scl      <= {r_scl[1:0], scl_i};
      r_sda      <= {r_sda[1:0], sda_i};
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ack      <= w_ack_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_stop_det <= w_stop_det_nxt;
      r_tvalid   <= w_tvalid_nxt;
      r_tdata    <= w_tdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_ack_nxt      = r_ack;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_stop_det_nxt = 1'b0;
    w_tvalid_nxt   = r_tvalid & ~m_axis_tready;
    w_tdata_nxt    = r_tdata;

    if (w_stop) begin
      w_state_nxt    = S_IDLE;
      w_cnt_nxt      = 3'd0;
      w_ack_nxt      = 1'b0;
      w_sda_oe_nxt   = 1'b0;
      w_busy_nxt     = 1'b0;
      w_stop_det_nxt = r_busy;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_cnt_nxt    = 3'd0;
      w_ack_nxt    = 1'b0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if (r_state == S_ADDR) begin
                w_ack_nxt   = w_match;
                w_busy_nxt  = w_match;
                w_state_nxt = S_ADDR_ACK;
              end else begin
                // Buffer full at the 8th bit means the byte is dropped and NACKed.
                w_ack_nxt   = ~r_tvalid;
                w_state_nxt = S_DATA_ACK;
                if (!r_tvalid) begin
                  w_tdata_nxt  = w_byte;
                  w_tvalid_nxt = 1'b1;
                end else begin
                  w_tdata_nxt  = r_tdata;
                end
              end
            end else begin
              w_state_nxt = r_state;
            end
          end else begin
            w_shift_nxt = r_shift;
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          // First SCL fall drives the ACK, the second one ends the 9th clock.
          if (!r_ack) begin
            w_state_nxt = S_IGNORE;
          end else if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_ack_nxt    = 1'b0;
              w_cnt_nxt    = 3'd0;
              w_state_nxt  = S_DATA;
            end
          end else begin
            w_sda_oe_nxt = r_sda_oe;
          end
        end
        S_IDLE, S_IGNORE: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign sda_oe        = r_sda_oe;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign stop_det      = r_stop_det;
  assign busy          = r_busy;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: a bit-banged I2C master on an open-drain SDA model,
// with a negedge monitor collecting stream beats, stop_det pulses and any SDA drive.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

  logic       clk = 1'b0;
  logic       arst;
  logic       scl_m;
  logic       sda_m;
  logic       tready;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] tdata;
  logic       tvalid;
  logic       stop_det;
  logic       busy;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] beat_q[$];
  int         stop_cnt = 0;
  bit         oe_seen  = 1'b0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_rx #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SLAVE_ADDR(7'h50)) dut (
    .clk           (clk),
    .arst          (arst),
    .scl_i         (scl_m),
    .sda_i         (sda_bus),
    .sda_oe        (sda_oe),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .stop_det      (stop_det),
    .busy          (busy)
  );

  always @(negedge clk) begin
    if (arst) begin
      if (tvalid && tready) beat_q.push_back(tdata);
      if (stop_det) stop_cnt = stop_cnt + 1;
      if (sda_oe) oe_seen = 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    beat_q.delete();
    stop_cnt = 0;
    oe_seen  = 1'b0;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; clk_wait(5);
    scl_m = 1'b1; clk_wait(5);
    sda_m = 1'b0; clk_wait(5);
    scl_m = 1'b0; clk_wait(5);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; clk_wait(5);
    scl_m = 1'b1; clk_wait(5);
    sda_m = 1'b1; clk_wait(10);
  endtask

  task automatic bus_bit(input logic b);
    sda_m = b;    clk_wait(5);
    scl_m = 1'b1; clk_wait(10);
    scl_m = 1'b0; clk_wait(5);
  endtask

  task automatic bus_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    sda_m = 1'b1; clk_wait(5);
    scl_m = 1'b1; clk_wait(5);
    ack = sda_oe & ~sda_bus;
    clk_wait(5);
    scl_m = 1'b0; clk_wait(5);
  endtask

  task automatic test_reset();
    arst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tready = 1'b1;
    clk_wait(4);
    tests_run++;
    if ({sda_oe, tvalid, stop_det, busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got oe/valid/stop/busy=%b, required 0000", {sda_oe, tvalid, stop_det, busy});
    end
    tests_run++;
    if (tdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_tdata: got %h, required 00", tdata);
    end
    arst = 1'b1;
    clk_wait(5);
  endtask

  task automatic test_addr_match();
    logic ack;
    clear_mon(); tready = 1'b1;
    bus_start();
    bus_byte(8'hA0, ack);
    tests_run++;
    if (ack !== 1'b1) begin tests_failed++; $display("FAIL match_addr_ack: got %b, required 1", ack); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL match_busy: got %b, required 1", busy); end
    bus_byte(8'hA5, ack);
    tests_run++;
    if (ack !== 1'b1) begin tests_failed++; $display("FAIL match_data_ack: got %b, required 1", ack); end
    bus_stop(); clk_wait(10);
    tests_run++;
    if (beat_q.size() != 1 || beat_q[0] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL match_beat: got %0d beats first=%h, required 1 beat A5", beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 8'hxx);
    end
    tests_run++;
    if (stop_cnt != 1) begin tests_failed++; $display("FAIL match_stop_det: got %0d pulses, required 1", stop_cnt); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL match_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_mismatch();
    logic ack0, ack1;
    clear_mon(); tready = 1'b1;
    bus_start();
    bus_byte(8'hA2, ack0);
    bus_byte(8'h3C, ack1);
    bus_stop(); clk_wait(10);
    tests_run++;
    if ({ack0, ack1} !== 2'b00) begin tests_failed++; $display("FAIL mismatch_ack: got %b, required 00", {ack0, ack1}); end
    tests_run++;
    if (oe_seen !== 1'b0) begin tests_failed++; $display("FAIL mismatch_sda_oe: got %b, required 0", oe_seen); end
    tests_run++;
    if (beat_q.size() != 0 || stop_cnt != 0) begin
      tests_failed++;
      $display("FAIL mismatch_out: got %0d beats %0d stops, required 0 and 0", beat_q.size(), stop_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic a0, a1, a2;
    clear_mon(); tready = 1'b0;
    bus_start();
    bus_byte(8'hA0, a0);
    bus_byte(8'h11, a1);
    bus_byte(8'h22, a2);
    tests_run++;
    if ({a0, a1, a2} !== 3'b110) begin tests_failed++; $display("FAIL bp_acks: got %b, required 110", {a0, a1, a2}); end
    tests_run++;
    if (tvalid !== 1'b1 || tdata !== 8'h11) begin
      tests_failed++;
      $display("FAIL bp_held: got valid=%b data=%h, required valid=1 data=11", tvalid, tdata);
    end
    bus_stop(); clk_wait(10);
    tests_run++;
    if (stop_cnt != 1 || beat_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_stop: got %0d stops %0d beats, required 1 and 0", stop_cnt, beat_q.size());
    end
    tready = 1'b1; clk_wait(5);
    tests_run++;
    if (beat_q.size() != 1 || beat_q[0] !== 8'h11) begin
      tests_failed++;
      $display("FAIL bp_drain: got %0d beats first=%h, required 1 beat 11", beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 8'hxx);
    end
    tests_run++;
    if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty: got valid=%b, required 0", tvalid); end
  endtask

  task automatic test_streaming();
    logic ack;
    int   ack_cnt;
    logic [7:0] exp_b;
    clear_mon(); tready = 1'b1; ack_cnt = 0;
    bus_start();
    bus_byte(8'hA0, ack);
    if (ack === 1'b1) ack_cnt++;
    for (int k = 1; k <= 4; k++) begin
      exp_b = k[7:0];
      bus_byte(exp_b, ack);
      if (ack === 1'b1) ack_cnt++;
    end
    bus_stop(); clk_wait(10);
    tests_run++;
    if (ack_cnt != 5) begin tests_failed++; $display("FAIL stream_acks: got %0d, required 5", ack_cnt); end
    tests_run++;
    if (beat_q.size() != 4) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d beats, required 4", beat_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_b = 8'(k + 1);
        tests_run++;
        if (beat_q[k] !== exp_b) begin
          tests_failed++;
          $display("FAIL stream_beat%0d: got %h, required %h", k, beat_q[k], exp_b);
        end
      end
    end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    clear_mon(); tready = 1'b1;
    bus_start();
    bus_byte(8'hA0, a0);
    bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1);
    bus_start();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rs_busy_clear: got %b, required 0", busy); end
    bus_byte(8'hA0, a1);
    bus_byte(8'h77, a2);
    bus_stop(); clk_wait(10);
    tests_run++;
    if ({a0, a1, a2} !== 3'b111) begin tests_failed++; $display("FAIL rs_acks: got %b, required 111", {a0, a1, a2}); end
    tests_run++;
    if (beat_q.size() != 1 || beat_q[0] !== 8'h77) begin
      tests_failed++;
      $display("FAIL rs_beat: got %0d beats first=%h, required 1 beat 77", beat_q.size(), (beat_q.size() > 0) ? beat_q[0] : 8'hxx);
    end
    tests_run++;
    if (stop_cnt != 1) begin tests_failed++; $display("FAIL rs_stop_det: got %0d, required 1", stop_cnt); end
  endtask

  task automatic test_read_reset();
    logic ack;
    logic [7:0] d;
    clear_mon(); tready = 1'b1;
    bus_start();
    bus_byte(8'hA1, ack);
    tests_run++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_nack: got ack=%b busy=%b, required 0 0", ack, busy);
    end
    bus_stop(); clk_wait(10);
    tests_run++;
    if (stop_cnt != 0 || oe_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_quiet: got %0d stops oe_seen=%b, required 0 and 0", stop_cnt, oe_seen);
    end
    tready = 1'b0;
    bus_start();
    bus_byte(8'hA0, ack);
    d = 8'h5A;
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    for (int i = 0; i < 20 && sda_oe !== 1'b1; i++) @(negedge clk);
    tests_run++;
    if (sda_oe !== 1'b1 || tvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_ack: got oe=%b valid=%b, required 1 1", sda_oe, tvalid);
    end
    @(posedge clk);
    #2 arst = 1'b0;
    #1;
    tests_run++;
    if ({sda_oe, tvalid, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_async: got oe/valid/busy=%b, required 000", {sda_oe, tvalid, busy});
    end
    clk_wait(3);
    scl_m = 1'b1; sda_m = 1'b1;
    clk_wait(2);
    arst = 1'b1; tready = 1'b1;
    clk_wait(10);
    tests_run++;
    if (beat_q.size() != 0 || tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_dropped: got %0d beats valid=%b, required 0 and 0", beat_q.size(), tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_addr_match();
    test_mismatch();
    test_backpressure();
    test_streaming();
    test_repeated_start();
    test_read_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
